// File: rtl/pmu_counter_bank.sv
// pmu_counter_bank: event-selectable performance counters with sticky overflow and interrupt.
// Define PMU_SNAPSHOT_EN to add a shadow bank captured by snap_i and read via rd_snap_i.
module pmu_counter_bank #(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 48,
  parameter int NUM_EVENTS    = 24,
  localparam int IDX_W = $clog2(NUM_COUNTERS),
  localparam int SEL_W = $clog2(NUM_EVENTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*NUM_EVENTS-1:0]  event_inc_i,
  input  logic                     freeze_i,
  input  logic                     cfg_we_i,
  input  logic [IDX_W-1:0]         cfg_idx_i,
  input  logic [SEL_W-1:0]         cfg_sel_i,
  input  logic                     cfg_en_i,
  input  logic                     cfg_irq_en_i,
  input  logic                     cnt_we_i,
  input  logic [IDX_W-1:0]         cnt_idx_i,
  input  logic [COUNTER_WIDTH-1:0] cnt_wdata_i,
  input  logic [NUM_COUNTERS-1:0]  ovf_clr_i,
  input  logic [IDX_W-1:0]         rd_idx_i,
  input  logic                     snap_i,
  input  logic                     rd_snap_i,
  output logic [COUNTER_WIDTH-1:0] rd_data_o,
  output logic [SEL_W+1:0]         rd_cfg_o,
  output logic [NUM_COUNTERS-1:0]  ovf_o,
  output logic                     irq_o
);
  localparam int W = COUNTER_WIDTH;
  logic [W-1:0]            cnt [NUM_COUNTERS];
  logic [SEL_W-1:0]        sel [NUM_COUNTERS];
  logic [W:0]              sum [NUM_COUNTERS];
  logic [1:0]              lane [NUM_EVENTS];
  logic [NUM_COUNTERS-1:0] en, irq_en, hit_cnt, hit_cfg, carry;
  logic                    rd_ok;
  logic [W-1:0]            rd_val;
  for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_lane
    assign lane[e] = event_inc_i[2*e +: 2];
  end
  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_ctr
    logic [1:0] inc;
    assign hit_cnt[i] = cnt_we_i && cnt_idx_i == IDX_W'(i);
    assign hit_cfg[i] = cfg_we_i && cfg_idx_i == IDX_W'(i);
    // a preload owns the counter this cycle, so its increment is dropped
    assign inc = (en[i] && !freeze_i && !hit_cnt[i] && sel[i] < SEL_W'(NUM_EVENTS)) ? lane[sel[i]] : 2'd0;
    assign sum[i] = {1'b0, cnt[i]} + {{(W-1){1'b0}}, inc};
    assign carry[i] = sum[i][W];
  end
  assign rd_ok = {1'b0, rd_idx_i} < (IDX_W+1)'(NUM_COUNTERS);
`ifdef PMU_SNAPSHOT_EN
  logic [W-1:0] shadow [NUM_COUNTERS];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NUM_COUNTERS; i++) shadow[i] <= '0;
    else if (snap_i) for (int i = 0; i < NUM_COUNTERS; i++) shadow[i] <= cnt[i];
  assign rd_val = rd_snap_i ? shadow[rd_idx_i] : cnt[rd_idx_i];
`else
  logic unused_snap;
  assign unused_snap = snap_i ^ rd_snap_i;
  assign rd_val = cnt[rd_idx_i];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt[i] <= '0;
        sel[i] <= '0;
      end
      en        <= '0;
      irq_en    <= '0;
      ovf_o     <= '0;
      rd_data_o <= '0;
      rd_cfg_o  <= '0;
      irq_o     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt[i] <= hit_cnt[i] ? cnt_wdata_i : sum[i][W-1:0];
        if (hit_cfg[i]) begin
          sel[i]    <= cfg_sel_i;
          en[i]     <= cfg_en_i;
          irq_en[i] <= cfg_irq_en_i;
        end
      end
      ovf_o     <= carry | (ovf_o & ~ovf_clr_i);
      irq_o     <= |(ovf_o & irq_en);
      rd_data_o <= rd_ok ? rd_val : '0;
      rd_cfg_o  <= rd_ok ? {irq_en[rd_idx_i], en[rd_idx_i], sel[rd_idx_i]} : '0;
    end
endmodule

// File: tb/tb_pmu_counter_bank.sv
// tb_pmu_counter_bank: scoreboard bench for pmu_counter_bank built with 8-bit counters.
module tb_pmu_counter_bank;
  localparam int NC = 4, W = 8, NE = 24, IW = 2, SW = 5;
  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW+1:0] cfg;
    logic          use_cfg;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [2*NE-1:0] ev = '0;
  logic freeze = 0, cfg_we = 0, cfg_en = 0, cfg_irq_en = 0, cnt_we = 0, snap = 0, rd_snap = 0;
  logic [IW-1:0] cfg_idx = '0, cnt_idx = '0, rd_idx = '0;
  logic [SW-1:0] cfg_sel = '0;
  logic [W-1:0] cnt_wdata = '0;
  logic [NC-1:0] ovf_clr = '0, ovf;
  logic [W-1:0] rd_data;
  logic [SW+1:0] rd_cfg;
  logic irq;
  logic rd_req = 0, rd_req_q = 0;
  exp_t sb [$];
  int total = 0, bad = 0;
  pmu_counter_bank #(.NUM_COUNTERS(NC), .COUNTER_WIDTH(W), .NUM_EVENTS(NE)) dut (
    .clk(clk), .rst(rst), .event_inc_i(ev), .freeze_i(freeze),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_sel_i(cfg_sel), .cfg_en_i(cfg_en),
    .cfg_irq_en_i(cfg_irq_en), .cnt_we_i(cnt_we), .cnt_idx_i(cnt_idx), .cnt_wdata_i(cnt_wdata),
    .ovf_clr_i(ovf_clr), .rd_idx_i(rd_idx), .snap_i(snap), .rd_snap_i(rd_snap),
    .rd_data_o(rd_data), .rd_cfg_o(rd_cfg), .ovf_o(ovf), .irq_o(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) rd_req_q <= rd_req;
  always @(negedge clk)
    if (rd_req_q) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", rd_data, e.data);
        if (e.use_cfg) chk("rd_cfg", rd_cfg, e.cfg);
      end
    end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic lane(input int e, input logic [1:0] v);
    ev[2*e +: 2] = v;
  endtask
  task automatic cfg(input int idx, input int s, input logic e, input logic ie);
    cfg_we = 1; cfg_idx = IW'(idx); cfg_sel = SW'(s); cfg_en = e; cfg_irq_en = ie;
    cyc(1);
    cfg_we = 0;
  endtask
  task automatic preload(input int idx, input logic [W-1:0] v);
    cnt_we = 1; cnt_idx = IW'(idx); cnt_wdata = v;
    cyc(1);
    cnt_we = 0;
  endtask
  task automatic rd(input int idx, input logic s, input logic [W-1:0] d, input logic [SW+1:0] c, input logic uc);
    rd_idx = IW'(idx); rd_snap = s; rd_req = 1;
    sb.push_back('{data: d, cfg: c, use_cfg: uc});
    cyc(1);
    rd_req = 0; rd_snap = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_cfg", rd_cfg, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_irq", irq, 0);
    rst = 0;
    cyc(1);
    cfg(0, 3, 1, 0);
    lane(3, 2);
    cyc(10);
    lane(3, 0);
    rd(0, 0, 8'd20, {1'b0, 1'b1, 5'd3}, 1);
    chk("t1_ovf", ovf, 0);
    cfg(1, 5, 1, 1);
    preload(1, 8'hFE);
    lane(5, 3);
    cyc(1);
    lane(5, 0);
    chk("t2_ovf_set", ovf[1], 1);
    chk("t2_irq_lag", irq, 0);
    cyc(1);
    chk("t2_irq", irq, 1);
    rd(1, 0, 8'h01, {1'b1, 1'b1, 5'd5}, 1);
    lane(3, 3);
    preload(0, 8'h55);
    lane(3, 0);
    rd(0, 0, 8'h55, '0, 0);
    preload(1, 8'hFF);
    lane(5, 1); ovf_clr = 4'b0010;
    cyc(1);
    lane(5, 0);
    chk("t3_set_wins", ovf[1], 1);
    cyc(1);
    ovf_clr = '0;
    chk("t3_clr", ovf[1], 0);
    chk("t3_irq_hold", irq, 1);
    cyc(1);
    chk("t3_irq_drop", irq, 0);
    rd(1, 0, 8'h00, '0, 0);
    freeze = 1; ev = '1;
    cyc(5);
    ev = '0;
    rd(0, 0, 8'h55, '0, 0);
    rd(1, 0, 8'h00, '0, 0);
    freeze = 0;
    cfg(2, NE, 1, 0);
    ev = '1;
    cyc(3);
    ev = '0;
    rd(2, 0, 8'h00, {1'b0, 1'b1, 5'd24}, 1);
    cfg(0, 7, 1, 0);
    preload(0, 8'd90);
    lane(7, 1);
    cyc(10);
    snap = 1;
    cyc(1);
    snap = 0;
    cyc(19);
    lane(7, 0);
`ifdef PMU_SNAPSHOT_EN
    rd(0, 1, 8'd100, '0, 0);
`else
    rd(0, 1, 8'd120, '0, 0);
`endif
    rd(0, 0, 8'd120, '0, 0);
    preload(1, 8'hFF);
    lane(5, 1); lane(7, 1);
    cyc(1);
    chk("t6_ovf_pre", ovf[1], 1);
    cyc(1);
    chk("t6_irq_pre", irq, 1);
    #2 rst = 1;
    #1;
    chk("t6_async_rd", rd_data, 0);
    chk("t6_async_ovf", ovf, 0);
    chk("t6_async_irq", irq, 0);
    #2 rst = 0;
    cyc(3);
    rd(0, 0, 8'h00, '0, 1);
    rd(1, 0, 8'h00, '0, 1);
    cfg(0, 7, 1, 0);
    cyc(5);
    rd(0, 0, 8'd5, {1'b0, 1'b1, 5'd7}, 1);
    ev = '0;
    cyc(2);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
